// File: rtl/fir_pkg.sv
// fir_pkg: definitions shared by the coefficient loader and the polyphase
// FIR decimator. Both blocks must size their coefficient address ranges the
// same way, so the derived sizes are computed here as functions.
//   ld_state_e : loader sequencer states
//   poly_num() : taps per polyphase branch
//   n_wr()     : coefficient writes per load (symmetric half, all branches)
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } ld_state_e;

  function automatic int poly_num(input int ord, input int m);
    return (ord + 1) / m;
  endfunction

  // Only the first half of each branch is sent; the decimator mirrors the rest.
  function automatic int n_wr(input int ord, input int m);
    return m * ((poly_num(ord, m) + 1) / 2);
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: sequences a symmetric half coefficient set from a host
// valid/ready stream into the decimator coefficient write port. It holds off
// the decimator sample flow while loading and for SETTLE_CYC cycles after the
// final write, then passes samples through.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle load request
//   s_valid/s_ready   coefficient beat handshake; s_data beat, s_last final beat
//   c_we/c_addr/c_in  registered decimator coefficient write port
//   smp_valid         upstream sample valid
//   flt_valid_in      sample valid to decimator, only passed in RUN
//   busy              LOAD or SETTLE
//   loaded            complete error-free set resident
//   done              one-cycle pulse on entry to RUN
//   err               sticky malformed-load flag, cleared by the next start
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int ORD        = 255,
  parameter int M          = 8,
  parameter int COEFF_SIZE = 16,
  parameter int SETTLE_CYC = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [COEFF_SIZE-1:0]     s_data,
  input  logic                      s_last,
  output logic                      c_we,
  output logic [$clog2(ORD+1)-1:0]  c_addr,
  output logic [COEFF_SIZE-1:0]     c_in,
  input  logic                      smp_valid,
  output logic                      flt_valid_in,
  output logic                      busy,
  output logic                      loaded,
  output logic                      done,
  output logic                      err
);

  localparam int POLY_NUM = poly_num(ORD, M);
  localparam int N_WR     = M * ((POLY_NUM + 1) / 2);
  localparam int AW       = $clog2(ORD + 1);
  localparam int SW       = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  localparam logic [AW-1:0] LAST_IDX    = AW'(N_WR - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam bit            NO_SETTLE   = (SETTLE_CYC == 0);

  ld_state_e       state_q;
  logic [AW-1:0]   wr_cnt;
  logic [SW-1:0]   settle_cnt;

  // Decoded straight from the state register: no extra sample latency, and
  // ready falls the cycle after the beat that leaves LOAD.
  assign s_ready      = (state_q == ST_LOAD);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
  assign flt_valid_in = smp_valid && (state_q == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_cnt     <= '0;
      settle_cnt <= '0;
      c_we       <= 1'b0;
      c_addr     <= '0;
      c_in       <= '0;
      loaded     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      c_we <= 1'b0;
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            wr_cnt  <= '0;
            loaded  <= 1'b0;
            err     <= 1'b0;
          end
        end

        // start is ignored here; a beat in the same cycle still goes through.
        ST_LOAD: begin
          if (s_valid) begin
            if (s_last && (wr_cnt != LAST_IDX)) begin
              // Short load: the marked beat is dropped, not written.
              err     <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              c_we   <= 1'b1;
              c_addr <= wr_cnt;
              c_in   <= s_data;
              wr_cnt <= wr_cnt + 1'b1;
              if (wr_cnt == LAST_IDX) begin
                if (s_last) begin
                  state_q    <= ST_SETTLE;
                  settle_cnt <= '0;
                end else begin
                  // Full count reached without a terminator: written, but flagged.
                  err     <= 1'b1;
                  state_q <= ST_IDLE;
                end
              end
            end
          end
        end

        ST_SETTLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            wr_cnt  <= '0;
            loaded  <= 1'b0;
            err     <= 1'b0;
          end else if (NO_SETTLE || (settle_cnt == SETTLE_LAST)) begin
            state_q <= ST_RUN;
            done    <= 1'b1;
            loaded  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (start) begin
            state_q <= ST_LOAD;
            wr_cnt  <= '0;
            loaded  <= 1'b0;
            err     <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader at default parameters. Expected writes are queued
// by the stimulus; a forked monitor pops and compares on every c_we.
module tb_fir_coeff_loader;

  localparam int CS = 16;
  localparam int SC = 200;
  localparam int NW = 128;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready, s_last;
  logic [CS-1:0] s_data, c_in;
  logic [AW-1:0] c_addr;
  logic          c_we, smp_valid, flt_valid_in, busy, loaded, done, err;

  always #5 clk = ~clk;

  fir_coeff_loader #(.ORD(255), .M(8), .COEFF_SIZE(CS), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .c_we(c_we), .c_addr(c_addr), .c_in(c_in),
    .smp_valid(smp_valid), .flt_valid_in(flt_valid_in),
    .busy(busy), .loaded(loaded), .done(done), .err(err)
  );

  typedef struct { int addr; int data; } wr_t;
  wr_t sb[$];
  wr_t mw;
  int  n_chk   = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  last_we = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then send n beats of data base+step*i. last_at marks the
  // beat carrying s_last (-1: none). Beats that should be written are queued.
  task automatic do_load(input int n, input int last_at, input bit gaps,
                         input int base, input int step);
    int          g;
    logic [15:0] d;
    wr_t         w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        s_valid = 1'b0;
        repeat (g) tick();
      end
      d       = 16'(base + step * i);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == last_at);
      chk("beat_ready", int'(s_ready), 1);
      if (!((i == last_at) && (i < NW - 1))) begin
        w.addr = i;
        w.data = int'(d);
        sb.push_back(w);
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({name, "_done_seen"}, int'(got), 1);
    if (got) begin
      chk({name, "_done_lat"}, cyc - last_we, SC);
      chk({name, "_loaded"}, int'(loaded), 1);
      chk({name, "_err"}, int'(err), 0);
      chk({name, "_sb_empty"}, sb.size(), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, int'({s_ready, c_we, busy, loaded, done, err, flt_valid_in}), 0);
    chk({name, "_addr"}, int'(c_addr), 0);
    chk({name, "_data"}, int'(c_in), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = '0; smp_valid = 1'b1;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (c_we) begin
          chk("we_while_flt", int'(flt_valid_in), 0);
          if (sb.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            mw = sb.pop_front();
            chk("wr_addr", int'(c_addr), mw.addr);
            chk("wr_data", int'(c_in), mw.data);
          end
          last_we = cyc;
        end
      end
    join_none

    // Reset state, with smp_valid high to show the gate is closed.
    repeat (3) tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    smp_valid = 1'b0;
    tick();

    // Nominal load 0x0001..0x0080.
    do_load(NW, NW - 1, 1'b0, 1, 1);
    wait_done("nom");
    chk("done_pulse_width", int'(done), 0);
    smp_valid = 1'b1;
    #1;
    chk("run_pass_hi", int'(flt_valid_in), 1);
    smp_valid = 1'b0;
    #1;
    chk("run_pass_lo", int'(flt_valid_in), 0);

    // Throttled source, started from RUN.
    do_load(NW, NW - 1, 1'b1, 16'h0100, 7);
    wait_done("thr");

    // Early s_last on beat 50: 49 writes, error, back to IDLE.
    do_load(50, 49, 1'b0, 16'h0200, 1);
    tick();
    tick();
    chk("early_err", int'(err), 1);
    chk("early_busy", int'(busy), 0);
    chk("early_loaded", int'(loaded), 0);
    chk("early_sb_empty", sb.size(), 0);
    smp_valid = 1'b1;
    #1;
    chk("early_flt_blocked", int'(flt_valid_in), 0);
    smp_valid = 1'b0;

    // Missing s_last: all 128 written, then error; next start clears err.
    do_load(NW, -1, 1'b0, 16'h0300, 1);
    tick();
    tick();
    chk("miss_err", int'(err), 1);
    chk("miss_loaded", int'(loaded), 0);
    chk("miss_busy", int'(busy), 0);
    chk("miss_sb_empty", sb.size(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("miss_err_cleared", int'(err), 0);
    chk("miss_restart_busy", int'(busy), 1);
    do_load(NW, NW - 1, 1'b0, 16'h0400, 1);  // its start pulse lands in LOAD and is ignored
    wait_done("miss_reload");

    // Reload from RUN with samples flowing; negative coefficients.
    smp_valid = 1'b1;
    #1;
    chk("reload_flt_before", int'(flt_valid_in), 1);
    start = 1'b1;
    #1;
    chk("reload_flt_start_cyc", int'(flt_valid_in), 1);
    tick();
    start = 1'b0;
    chk("reload_flt_after", int'(flt_valid_in), 0);
    chk("reload_loaded_drop", int'(loaded), 0);
    do_load(NW, NW - 1, 1'b1, -100, 3);
    wait_done("reload");
    chk("reload_flt_run", int'(flt_valid_in), 1);
    smp_valid = 1'b0;

    // Async reset after 64 beats.
    do_load(64, -1, 1'b0, 16'h0500, 1);
    tick();
    smp_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    chk("rst_mid_sb_empty", sb.size(), 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    smp_valid = 1'b0;
    tick();
    do_load(NW, NW - 1, 1'b0, 16'h0600, 1);
    wait_done("post_rst");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
